// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared constants, FSM encoding and event record for the keypad encoder
package keypad_pkg;

  localparam logic [15:0] KEYCODE_EMPTY = 16'hFFFF;
  localparam int          KEY_IDX_W     = 4;
  localparam int          EVT_W         = KEY_IDX_W + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic [KEY_IDX_W-1:0] key;
    logic                 press;
  } key_evt_t;

  // Raw matrix is active-low with key n on bit 15-n; debounced state is active-high, key n on bit n.
  function automatic logic [15:0] keycode_to_state(input logic [15:0] raw);
    logic [15:0] s;
    for (int n = 0; n < 16; n++) s[n] = ~raw[15-n];
    return s;
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// rtl/key_evt_fifo.sv - synchronous event FIFO with registered occupancy count
module key_evt_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_wr;
  logic             do_rd;

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign do_wr    = push && !full;
  assign do_rd    = pop && !empty;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_event_encoder.sv
// rtl/key_event_encoder.sv - debounced 4x4 keypad scanner emitting ordered press/release events
module key_event_encoder
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] keycode,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [3:0]  evt_key,
  output logic        evt_press,
  output logic [15:0] key_state,
  output logic        busy
);

  localparam int                CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] STAB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [15:0]          prev;
  logic [CNT_W-1:0]     stab_cnt;
  scan_state_t          state;
  logic [KEY_IDX_W-1:0] idx;
  logic [15:0]          target;
  logic [15:0]          target_now;
  logic                 stable;
  logic                 differs;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 stall;
  key_evt_t             push_evt;
  key_evt_t             head_evt;

  assign target_now = keycode_to_state(prev);
  assign stable     = (stab_cnt == STAB_MAX);
  assign differs    = (target[idx] != key_state[idx]);
  assign push       = (state == ST_SCAN) && differs && !fifo_full;
  assign stall      = (state == ST_SCAN) && differs && fifo_full;
  assign push_evt   = '{key: idx, press: target[idx]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev     <= KEYCODE_EMPTY;
      stab_cnt <= '0;
    end else begin
      prev <= keycode;
      if (keycode != prev)        stab_cnt <= '0;
      else if (stab_cnt != STAB_MAX) stab_cnt <= stab_cnt + CNT_W'(1);
    end
  end

  // Target is latched at scan start so matrix activity mid-scan only restarts debouncing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      target    <= '0;
      key_state <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (stable && (target_now != key_state)) begin
            state  <= ST_SCAN;
            target <= target_now;
            idx    <= '0;
            busy   <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (!stall) begin
            if (push) key_state[idx] <= target[idx];
            idx <= idx + KEY_IDX_W'(1);
            if (idx == KEY_IDX_W'(15)) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  key_evt_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .WIDTH     (EVT_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_evt),
    .pop      (evt_valid && evt_ready),
    .pop_data (head_evt),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign evt_key   = head_evt.key;
  assign evt_press = head_evt.press;

endmodule

// File: tb/tb_key_event_encoder.sv
// tb/tb_key_event_encoder.sv - randomized self-checking bench for key_event_encoder
module tb_key_event_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] keycode = 16'hFFFF;
  logic        evt_ready = 1'b0;
  logic        evt_valid;
  logic [3:0]  evt_key;
  logic        evt_press;
  logic [15:0] key_state;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int hold_errs = 0;
  logic [4:0] got[$];
  logic [15:0] model_state = 16'h0000;

  logic       last_stall = 1'b0;
  logic [4:0] last_data = 5'd0;

  key_event_encoder #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .keycode  (keycode),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_key  (evt_key),
    .evt_press(evt_press),
    .key_state(key_state),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Records accepted events and checks that a stalled head stays put.
  always @(negedge clk) begin
    if (!reset) begin
      last_stall = 1'b0;
    end else begin
      if (last_stall && !(evt_valid && ({evt_key, evt_press} == last_data))) hold_errs++;
      if (evt_valid && evt_ready) got.push_back({evt_key, evt_press});
      last_stall = evt_valid && !evt_ready;
      last_data  = {evt_key, evt_press};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_wait(input int min_cycles, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      step();
      if (c >= min_cycles && !busy && !evt_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    keycode = 16'hFFFF;
    evt_ready = 1'b0;
    step(); step();
    checks++;
    if ({evt_valid, evt_key, evt_press, busy, key_state} !== 23'd0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b key=%0d press=%b busy=%b state=%h, want all zero",
               evt_valid, evt_key, evt_press, busy, key_state);
    end
    reset = 1'b1;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if ({evt_valid, busy, key_state} !== 18'd0 || got.size() != 0) begin
      failures++;
      $display("FAIL reset_idle: got valid=%b busy=%b state=%h events=%0d, want idle with no events",
               evt_valid, busy, key_state, got.size());
    end
  endtask

  task automatic test_single_press();
    int base;
    int lat;
    base = got.size();
    lat = 0;
    evt_ready = 1'b1;
    keycode = 16'h7FFF;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (lat == 0 && evt_valid) lat = c;
    end
    checks++;
    if (lat != 6) begin
      failures++;
      $display("FAIL press_latency: got %0d cycles, want 6", lat);
    end
    checks++;
    if (got.size() - base != 1) begin
      failures++;
      $display("FAIL press_count: got %0d events, want 1", got.size() - base);
    end else begin
      checks++;
      if (got[base] !== 5'b0000_1) begin
        failures++;
        $display("FAIL press_event: got %b, want key0 press", got[base]);
      end
    end
    checks++;
    if (key_state !== 16'h0001) begin
      failures++;
      $display("FAIL press_state: got %h, want 0001", key_state);
    end
    model_state = 16'h0001;
  endtask

  task automatic test_bounce();
    int base;
    base = got.size();
    for (int i = 0; i < 10; i++) begin
      keycode = (i % 2 == 0) ? 16'hFFFF : 16'h7FFF;
      step(); step();
    end
    keycode = 16'h7FFF;
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (got.size() != base || key_state !== 16'h0001 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bounce: got events=%0d state=%h busy=%b, want 0 events state 0001 idle",
               got.size() - base, key_state, busy);
    end
  endtask

  task automatic test_stall_and_drain();
    int base;
    bit ok;
    reset = 1'b0;
    keycode = 16'hFFFF;
    step();
    reset = 1'b1;
    model_state = 16'h0000;
    base = got.size();
    evt_ready = 1'b0;
    keycode = 16'h0000;
    for (int i = 0; i < 30; i++) step();
    checks++;
    if (busy !== 1'b1 || key_state !== 16'h000F || evt_valid !== 1'b1 ||
        {evt_key, evt_press} !== 5'b0000_1 || got.size() != base) begin
      failures++;
      $display("FAIL stall: got busy=%b state=%h valid=%b head=%0d/%b, want busy 000F head key0 press",
               busy, key_state, evt_valid, evt_key, evt_press);
    end
    evt_ready = 1'b1;
    drain_wait(0, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stall_drain_timeout: got busy=%b valid=%b, want idle", busy, evt_valid);
    end
    checks++;
    if (got.size() - base != 16) begin
      failures++;
      $display("FAIL stall_count: got %0d events, want 16", got.size() - base);
    end else begin
      for (int n = 0; n < 16; n++) begin
        checks++;
        if (got[base+n] !== {n[3:0], 1'b1}) begin
          failures++;
          $display("FAIL stall_order[%0d]: got %b, want key %0d press", n, got[base+n], n);
        end
      end
    end
    checks++;
    if (key_state !== 16'hFFFF) begin
      failures++;
      $display("FAIL stall_state: got %h, want FFFF", key_state);
    end
    model_state = 16'hFFFF;
  endtask

  task automatic test_release_all();
    int base;
    bit ok;
    base = got.size();
    keycode = 16'hFFFF;
    drain_wait(10, ok);
    checks++;
    if (!ok || got.size() - base != 16) begin
      failures++;
      $display("FAIL release_count: got %0d events ok=%b, want 16", got.size() - base, ok);
    end else begin
      for (int n = 0; n < 16; n++) begin
        checks++;
        if (got[base+n] !== {n[3:0], 1'b0}) begin
          failures++;
          $display("FAIL release_order[%0d]: got %b, want key %0d release", n, got[base+n], n);
        end
      end
    end
    checks++;
    if (key_state !== 16'h0000) begin
      failures++;
      $display("FAIL release_state: got %h, want 0000", key_state);
    end
    model_state = 16'h0000;
  endtask

  task automatic test_reset_mid_scan();
    int base;
    int guard;
    base = got.size();
    evt_ready = 1'b1;
    keycode = 16'h0000;
    guard = 0;
    while (got.size() - base < 6 && guard < 100) begin
      step();
      guard++;
    end
    checks++;
    if (guard >= 100) begin
      failures++;
      $display("FAIL midscan_setup: got %0d events, want 6", got.size() - base);
    end
    #2;
    reset = 1'b0;
    keycode = 16'hFFFF;
    #1;
    checks++;
    if (evt_valid !== 1'b0 || key_state !== 16'h0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midscan_reset: got valid=%b state=%h busy=%b, want cleared", evt_valid, key_state, busy);
    end
    step();
    reset = 1'b1;
    model_state = 16'h0000;
    base = got.size();
    for (int i = 0; i < 40; i++) step();
    checks++;
    if (got.size() != base || key_state !== 16'h0000) begin
      failures++;
      $display("FAIL midscan_after: got %0d events state=%h, want none", got.size() - base, key_state);
    end
  endtask

  task automatic test_random();
    logic [15:0] kc;
    logic [15:0] g;
    logic [15:0] tgt;
    logic [4:0]  expq[$];
    int          base;
    int          len;
    bit          ok;
    for (int it = 0; it < 12; it++) begin
      for (int gl = 0; gl < int'($urandom_range(0, 3)); gl++) begin
        do g = 16'($urandom); while (g == keycode);
        keycode = g;
        len = $urandom_range(1, 3);
        for (int k = 0; k < len; k++) begin
          step();
          evt_ready = 1'($urandom_range(0, 1));
        end
      end
      kc = (it % 3 == 0) ? 16'($urandom) : (16'hFFFF ^ (16'd1 << $urandom_range(0, 15)) ^ (16'd1 << $urandom_range(0, 15)));
      base = got.size();
      expq.delete();
      for (int n = 0; n < 16; n++) begin
        tgt[n] = ~kc[15-n];
        if (tgt[n] != model_state[n]) expq.push_back({n[3:0], tgt[n]});
      end
      keycode = kc;
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
        step();
        evt_ready = 1'($urandom_range(0, 1));
        if (c >= 10 && !busy && !evt_valid) begin
          ok = 1'b1;
          break;
        end
      end
      checks++;
      if (!ok || got.size() - base != expq.size()) begin
        failures++;
        $display("FAIL rand%0d_count: got %0d events ok=%b, want %0d", it, got.size() - base, ok, expq.size());
      end else begin
        for (int e = 0; e < expq.size(); e++) begin
          checks++;
          if (got[base+e] !== expq[e]) begin
            failures++;
            $display("FAIL rand%0d_evt%0d: got %b, want %b", it, e, got[base+e], expq[e]);
          end
        end
      end
      checks++;
      if (key_state !== tgt) begin
        failures++;
        $display("FAIL rand%0d_state: got %h, want %h", it, key_state, tgt);
      end
      model_state = tgt;
    end
  endtask

  task automatic test_hold_steady();
    checks++;
    if (hold_errs != 0) begin
      failures++;
      $display("FAIL hold_steady: got %0d head changes under backpressure, want 0", hold_errs);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_stall_and_drain();
    test_release_all();
    test_reset_mid_scan();
    test_random();
    test_hold_steady();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_event_encoder.md
KEY_EVENT_ENCODER -- requirements
Module: key_event_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000: consecutive identical keycode samples required before a vector is accepted.
REQ-002 Parameter FIFO_DEPTH, default 4: event queue entries, power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 keycode  input  16  raw scanned key matrix, active-low (0 = pressed); bit 15-n is key n; key n = row n/4, column n%4.
REQ-006 evt_valid  output  1  head-of-queue event present.
REQ-007 evt_ready  input  1  consumer accepts head event.
REQ-008 evt_key  output  4  key index 0..15 of the head event.
REQ-009 evt_press  output  1  1 = press event, 0 = release event.
REQ-010 key_state  output  16  debounced key state, active-high, bit n = key n.
REQ-011 busy  output  1  high while the scanner FSM is in SCAN.

Function
REQ-012 The stability stage shall register keycode into prev each cycle; if keycode != prev, stab_cnt <= 0, else stab_cnt increments, saturating at DEBOUNCE_CYCLES-1.
REQ-013 A vector is stable when stab_cnt == DEBOUNCE_CYCLES-1; stable target = bit-reversed inversion of prev, so target bit n = ~prev[15-n].
REQ-014 FSM states: IDLE, SCAN; IDLE -> SCAN when the vector is stable and target != key_state; target latched and idx <= 0 on that transition.
REQ-015 In SCAN, each cycle: if target[idx] == key_state[idx], idx advances; otherwise, if the FIFO is not full, push {idx, target[idx]}, set key_state[idx] <= target[idx], and advance idx; if the FIFO is full, hold idx (stall) with no push.
REQ-016 SCAN -> IDLE in the cycle idx == 15 completes (advance or push); a stall at idx 15 keeps SCAN.
REQ-017 Keycode changes during SCAN shall not alter the latched target; they restart stab_cnt only, and are re-evaluated in IDLE.
REQ-018 Events shall be emitted in ascending key index order within one scan; no event is ever dropped.
REQ-019 FIFO full is computed from the registered count: a push is blocked when count == FIFO_DEPTH even if a pop occurs in the same cycle.
REQ-020 Pop on evt_valid && evt_ready; simultaneous push and pop on a non-full, non-empty FIFO leaves count unchanged.
REQ-021 A pushed event shall appear on evt_key/evt_press with evt_valid high on the cycle after the push (latency 1 when the FIFO was empty).
REQ-022 evt_key/evt_press shall hold steady while evt_valid && !evt_ready.
REQ-023 The FIFO read and write pointers shall wrap modulo FIFO_DEPTH.
REQ-024 Minimum latency from a keycode change to the first event is DEBOUNCE_CYCLES+2 cycles.

Reset
REQ-025 On reset low, asynchronously: prev = 16'hFFFF, stab_cnt = 0, state = IDLE, idx = 0, key_state = 0, FIFO empty, evt_valid = 0, evt_key = 0, evt_press = 0, busy = 0.
REQ-026 Reset asserted mid-SCAN shall discard pending and queued events; after release, no events are emitted until a new stable vector differs from all-released.

Structure
REQ-027 Shared package keypad_pkg shall hold KEYCODE_EMPTY (16'hFFFF), the key-index width (4), the FSM state encoding, and the event record width (5 bits: key, press).
REQ-028 Sub-module key_evt_fifo shall be a synchronous FIFO (parameters FIFO_DEPTH and width 5) with push/pop/full/empty; the FSM and debounce logic stay in the top module.

Verification (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4)
REQ-029 keycode 16'hFFFF -> 16'h7FFF held 10 cycles, evt_ready=1 -> exactly one event, key=0, press=1, 6 cycles after the change; key_state=16'h0001.
REQ-030 From that state, keycode toggles 16'h7FFF/16'hFFFF every 2 cycles for 20 cycles, then 16'h7FFF -> no events; key_state stays 16'h0001.
REQ-031 keycode 16'h0000 stable, evt_ready=0 -> 4 events queued (keys 0..3), busy stays high, FSM stalls at idx 4; evt_ready=1 -> events for keys 4..15 follow in order, 16 total, then busy=0.
REQ-032 From all keys pressed, keycode -> 16'hFFFF stable -> 16 release events, keys 0..15 ascending, each press=0; key_state=0.
REQ-033 Reset pulsed during the 031 scan after 6 events -> evt_valid=0 and key_state=0 immediately; keycode 16'hFFFF after release -> no events.
REQ-034 Full FIFO with evt_ready=1 on the cycle a push is pending -> pop occurs, push waits one cycle, no event lost or duplicated.
